// File: rtl/banco_registro_clr.sv
// banco_registro_clr: 2-read/1-write register bank with registered reads and
// a hardware clear sweep that zeroes one entry per cycle after reset/clr_req.
// Ports:
//   clk, rst (async, active low)
//   addrRa/addrRb -> datOutRa/datOutRb (1-cycle read latency)
//   addrW, datW, RegWrite (write port)
//   clr_req (start sweep), busy (sweep running), wr_drop (refused write)
// Build option: BANCO_BYPASS_EN selects write-first on read/write collisions;
// when undefined, a colliding read returns the old stored value.
module banco_registro_clr #(
  parameter int BIT_ADDR = 3,
  parameter int BIT_DATO = 8,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] addrRa,
  input  logic [BIT_ADDR-1:0] addrRb,
  output logic [BIT_DATO-1:0] datOutRa,
  output logic [BIT_DATO-1:0] datOutRb,
  input  logic [BIT_ADDR-1:0] addrW,
  input  logic [BIT_DATO-1:0] datW,
  input  logic                RegWrite,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_drop
);

  localparam int NREG = 2**BIT_ADDR;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [BIT_ADDR-1:0] ptr;
  logic [BIT_ADDR-1:0] ptrNext;

  logic [BIT_DATO-1:0] breg [NREG];

  logic                clearing;
  logic                zeroHitW;
  logic                wrOk;
  logic [BIT_DATO-1:0] rdA;
  logic [BIT_DATO-1:0] rdB;

  assign clearing = (state == CLEAR);
  assign busy     = clearing;
  assign zeroHitW = ZERO_REG && (addrW == '0);
  // Writes land only in IDLE; the hard-wired zero entry swallows them.
  assign wrOk     = !clearing && RegWrite && !zeroHitW;

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    unique case (state)
      CLEAR: begin
        ptrNext = ptr + 1'b1;
        if (ptr == '1) begin
          stateNext = IDLE;
          ptrNext   = '0;
        end
      end
      IDLE: begin
        if (clr_req) begin
          stateNext = CLEAR;
        end
      end
      default: begin
        stateNext = CLEAR;
        ptrNext   = '0;
      end
    endcase
  end

  always_comb begin
    rdA = breg[addrRa];
    rdB = breg[addrRb];
`ifdef BANCO_BYPASS_EN
    if (wrOk && (addrRa == addrW)) rdA = datW;
    if (wrOk && (addrRb == addrW)) rdB = datW;
`endif
    if (ZERO_REG && (addrRa == '0)) rdA = '0;
    if (ZERO_REG && (addrRb == '0)) rdB = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      ptr      <= '0;
      datOutRa <= '0;
      datOutRb <= '0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      wr_drop  <= clearing && RegWrite;
      datOutRa <= clearing ? '0 : rdA;
      datOutRb <= clearing ? '0 : rdB;
    end
  end

  // Storage has no reset; the sweep is what gives it known contents.
  // A write coinciding with clr_req lands first and is zeroed later.
  always_ff @(posedge clk) begin
    if (clearing) begin
      breg[ptr] <= '0;
    end else if (wrOk) begin
      breg[addrW] <= datW;
    end
  end

endmodule

// File: tb/tb_banco_registro_clr.sv
// tb_banco_registro_clr: directed bench for banco_registro_clr, two instances
// (ZERO_REG = 0 and 1) driven in parallel and checked against a bank model.
module tb_banco_registro_clr;

  localparam int NREG = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] addrRa = '0;
  logic [2:0] addrRb = '0;
  logic [2:0] addrW = '0;
  logic [7:0] datW = '0;
  logic       RegWrite = 1'b0;
  logic       clr_req = 1'b0;

  logic [7:0] outA0, outB0, outA1, outB1;
  logic       busy0, busy1, drop0, drop1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banco_registro_clr #(.BIT_ADDR(3), .BIT_DATO(8), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .addrRa(addrRa), .addrRb(addrRb),
    .datOutRa(outA0), .datOutRb(outB0),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite),
    .clr_req(clr_req), .busy(busy0), .wr_drop(drop0)
  );

  banco_registro_clr #(.BIT_ADDR(3), .BIT_DATO(8), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .addrRa(addrRa), .addrRb(addrRb),
    .datOutRa(outA1), .datOutRb(outB1),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite),
    .clr_req(clr_req), .busy(busy1), .wr_drop(drop1)
  );

  // Model: a clear is seen as "whole bank becomes zero" plus a countdown of
  // NREG busy cycles during which outputs are zero and writes are refused.
  logic [7:0] mem [2][NREG];
  logic [7:0] expA [2];
  logic [7:0] expB [2];
  logic       expDrop = 1'b0;
  int         sweep = NREG;

  function automatic logic [7:0] rdModel(int z, logic [2:0] a);
    logic [7:0] v;
    v = mem[z][a];
    if (z == 1 && a == 3'd0) return 8'h00;
`ifdef BANCO_BYPASS_EN
    if (RegWrite && a == addrW) v = datW;
`endif
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep   = NREG;
      expDrop = 1'b0;
      for (int z = 0; z < 2; z++) begin
        expA[z] = 8'h00;
        expB[z] = 8'h00;
        for (int i = 0; i < NREG; i++) mem[z][i] = 8'h00;
      end
    end else if (sweep > 0) begin
      sweep   = sweep - 1;
      expDrop = RegWrite;
      for (int z = 0; z < 2; z++) begin
        expA[z] = 8'h00;
        expB[z] = 8'h00;
      end
    end else begin
      expDrop = 1'b0;
      for (int z = 0; z < 2; z++) begin
        expA[z] = rdModel(z, addrRa);
        expB[z] = rdModel(z, addrRb);
      end
      if (RegWrite) begin
        mem[0][addrW] = datW;
        if (addrW != 3'd0) mem[1][addrW] = datW;
      end
      if (clr_req) begin
        sweep = NREG;
        for (int z = 0; z < 2; z++)
          for (int i = 0; i < NREG; i++) mem[z][i] = 8'h00;
      end
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("m_A0", outA0, expA[0]);
    chk("m_B0", outB0, expB[0]);
    chk("m_A1", outA1, expA[1]);
    chk("m_B1", outB1, expB[1]);
    chk("m_busy0", {7'b0, busy0}, {7'b0, (sweep > 0)});
    chk("m_busy1", {7'b0, busy1}, {7'b0, (sweep > 0)});
    chk("m_drop0", {7'b0, drop0}, {7'b0, expDrop});
    chk("m_drop1", {7'b0, drop1}, {7'b0, expDrop});
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {7'b0, busy0}, 8'h01);
    chk("rst_out", outA0, 8'h00);
    rst = 1'b1;
    n = 0;
    while (busy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_busy_len", 8'(n), 8'd8);

    for (int a = 0; a < NREG; a++) begin
      addrRa = 3'(a);
      addrRb = 3'(a);
      @(negedge clk);
      chk("init_rdA", outA0, 8'h00);
      chk("init_rdB", outB0, 8'h00);
    end

    addrW = 3'd5; datW = 8'hA5; RegWrite = 1'b1;
    @(negedge clk);
    RegWrite = 1'b0; addrRa = 3'd5; addrRb = 3'd5;
    @(negedge clk);
    chk("wr_a5_A", outA0, 8'hA5);
    chk("wr_a5_B", outB0, 8'hA5);

    addrW = 3'd2; datW = 8'h3C; RegWrite = 1'b1;
    addrRa = 3'd2; addrRb = 3'd2;
    @(negedge clk);
    RegWrite = 1'b0;
`ifdef BANCO_BYPASS_EN
    chk("coll_new", outA0, 8'h3C);
`else
    chk("coll_old", outA0, 8'h00);
`endif
    @(negedge clk);
    chk("coll_next", outA0, 8'h3C);

    RegWrite = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      addrW = 3'(i);
      datW  = 8'((i + 1) * 17);
      @(negedge clk);
    end
    RegWrite = 1'b0;
    addrRa = 3'd7; addrRb = 3'd0;
    @(negedge clk);
    chk("fill7", outA0, 8'h88);
    chk("fill0_z0", outB0, 8'h11);
    chk("fill0_z1", outB1, 8'h00);

    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (busy0 && n < 50) begin
      if (n == 2) begin
        RegWrite = 1'b1; addrW = 3'd3; datW = 8'h77;
      end else begin
        RegWrite = 1'b0;
      end
      if (n == 3) chk("drop_pulse", {7'b0, drop0}, 8'h01);
      if (n == 4) chk("drop_end", {7'b0, drop0}, 8'h00);
      if (n >= 1) chk("sweep_out", outA0, 8'h00);
      @(negedge clk);
      n++;
    end
    RegWrite = 1'b0;
    chk("clr_busy_len", 8'(n), 8'd8);

    for (int a = 0; a < NREG; a++) begin
      addrRa = 3'(a);
      addrRb = 3'(a);
      @(negedge clk);
      chk("clr_rdA", outA0, 8'h00);
      chk("clr_rdB", outB0, 8'h00);
    end

    addrW = 3'd0; datW = 8'hFF; RegWrite = 1'b1;
    addrRa = 3'd0; addrRb = 3'd0;
    @(negedge clk);
    RegWrite = 1'b0;
    chk("z1_nodrop", {7'b0, drop1}, 8'h00);
    @(negedge clk);
    chk("z1_rd0", outA1, 8'h00);
    chk("z0_rd0", outA0, 8'hFF);

    addrW = 3'd1; datW = 8'h42; RegWrite = 1'b1;
    addrRa = 3'd1; addrRb = 3'd1;
    @(negedge clk);
    RegWrite = 1'b0;
    @(negedge clk);
    chk("z1_rd1", outA1, 8'h42);

    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (busy0 && n < 50) begin
      chk("rst2_out", outA0, 8'h00);
      @(negedge clk);
      n++;
    end
    chk("rst2_busy_len", 8'(n), 8'd8);
    @(negedge clk);
    chk("rst2_rd1", outA1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
